// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared encodings for the immediate-extension stage.
//   - Extension mode encodings carried on in_mode.
//   - State encodings of the 2-entry skid buffer, named by occupancy.
package imm_ext_pkg;

    localparam int IMM_MODE_W = 2;

    typedef enum logic [IMM_MODE_W-1:0] {
        IMM_SIGN   = 2'd0,
        IMM_ZERO   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/skid_buf.sv
// skid_buf: two-entry valid/ready buffer with synchronous flush.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   flush          squash held and incoming entries (wins over transfers)
//   in_valid/in_ready/in_data     upstream handshake; in_ready is a flop
//   out_valid/out_ready/out_data  downstream handshake; out_valid is a flop
// The output register presents the head entry; the skid register holds a
// second entry accepted in the cycle out_ready dropped.
module skid_buf
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 37
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    skid_state_e       state;
    logic [DATA_W-1:0] data_p1;
    logic [DATA_W-1:0] skid_p1;
    logic              vld_p1;
    logic              rdy_p1;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer   = in_valid & rdy_p1;
    assign out_xfer  = vld_p1 & out_ready;
    assign in_ready  = rdy_p1;
    assign out_valid = vld_p1;
    assign out_data  = data_p1;

    // p0 -> p1: state, handshake flags and both data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_EMPTY;
            vld_p1  <= 1'b0;
            rdy_p1  <= 1'b1;
            data_p1 <= '0;
            skid_p1 <= '0;
        end else if (flush) begin
            state   <= ST_EMPTY;
            vld_p1  <= 1'b0;
            rdy_p1  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        data_p1 <= in_data;
                        state   <= ST_ONE;
                        vld_p1  <= 1'b1;
                        rdy_p1  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        data_p1 <= in_data;
                    end else if (in_xfer) begin
                        // Downstream stalled: park the new entry behind the head.
                        skid_p1 <= in_data;
                        state   <= ST_TWO;
                        rdy_p1  <= 1'b0;
                    end else if (out_xfer) begin
                        state   <= ST_EMPTY;
                        vld_p1  <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        data_p1 <= skid_p1;
                        state   <= ST_ONE;
                        rdy_p1  <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_EMPTY;
                    vld_p1 <= 1'b0;
                    rdy_p1 <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: immediate extension for the decode path.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous squash of held/incoming entries
//   in_valid/in_ready        input handshake (in_ready registered)
//   in_imm, in_mode, in_tag  raw immediate, extension mode, sideband tag
//   out_valid/out_ready      output handshake (out_valid registered)
//   out_data, out_tag        extended operand and its tag
// Extension is combinational on the input side; only the extended operand
// and tag are buffered, in a 2-entry skid buffer.
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_imm,
    input  logic [IMM_MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic [TAG_W-1:0]      out_tag
);

    function automatic logic [OUT_W-1:0] ext_imm(
        input logic [IN_W-1:0]       imm,
        input logic [IMM_MODE_W-1:0] mode
    );
        logic signed [OUT_W-1:0] sext;
        logic [OUT_W-1:0]        res;
        sext = signed'({{(OUT_W-IN_W){imm[IN_W-1]}}, imm});
        case (mode)
            IMM_SIGN:   res = sext;
            IMM_ZERO:   res = {{(OUT_W-IN_W){1'b0}}, imm};
            IMM_UPPER:  res = {imm, {(OUT_W-IN_W){1'b0}}};
            // Word-aligned branch offset: sign-extended, scaled by 4.
            IMM_BRANCH: res = {sext[OUT_W-3:0], 2'b00};
            default:    res = sext;
        endcase
        return res;
    endfunction

    logic [OUT_W-1:0]       ext_p0;
    logic [OUT_W+TAG_W-1:0] buf_out;

    // p0: extension ahead of the buffer
    assign ext_p0 = ext_imm(in_imm, in_mode);

    skid_buf #(
        .DATA_W (OUT_W + TAG_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({ext_p0, in_tag}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign out_data = buf_out[OUT_W+TAG_W-1:TAG_W];
    assign out_tag  = buf_out[TAG_W-1:0];

endmodule
